// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and defaults for the register-file write-back arbiter
package wb_pkg;
  localparam int REG_IDX_W        = 5;
  localparam int XLEN             = 32;
  localparam int DEF_DEPTH        = 4;
  localparam int DEF_STARVE_LIMIT = 8;

  typedef struct packed {
    logic                 fp;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - write-back, long-latency, issue and register-file signals
interface regfile_wb_arbiter_if;
  import wb_pkg::*;

  logic                 pipe_wb_valid;
  logic                 pipe_wb_fp;
  logic [REG_IDX_W-1:0] pipe_wb_rd;
  logic [XLEN-1:0]      pipe_wb_data;
  logic                 lu_valid;
  logic                 lu_ready;
  logic                 lu_fp;
  logic [REG_IDX_W-1:0] lu_rd;
  logic [XLEN-1:0]      lu_data;
  logic                 iss_valid;
  logic                 iss_fp;
  logic [REG_IDX_W-1:0] iss_rd;
  logic                 int_wen;
  logic                 fp_wen;
  logic [REG_IDX_W-1:0] rd_idx;
  logic [XLEN-1:0]      wr_data;
  logic [31:0]          sb_busy_int;
  logic [31:0]          sb_busy_fp;
  logic                 wb_stall_req;

  modport master (
    output pipe_wb_valid, pipe_wb_fp, pipe_wb_rd, pipe_wb_data,
    output lu_valid, lu_fp, lu_rd, lu_data, iss_valid, iss_fp, iss_rd,
    input  lu_ready, int_wen, fp_wen, rd_idx, wr_data,
    input  sb_busy_int, sb_busy_fp, wb_stall_req
  );

  modport slave (
    input  pipe_wb_valid, pipe_wb_fp, pipe_wb_rd, pipe_wb_data,
    input  lu_valid, lu_fp, lu_rd, lu_data, iss_valid, iss_fp, iss_rd,
    output lu_ready, int_wen, fp_wen, rd_idx, wr_data,
    output sb_busy_int, sb_busy_fp, wb_stall_req
  );
endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of long-latency write-back requests
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);

  wb_req_t     mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - merges pipeline and long-latency write-back onto one port, tracks pending writes
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave wb
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  wb_req_t       lu_req;
  wb_req_t       head;
  wb_req_t       owner;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          owner_valid;
  logic [31:0]   busy_int;
  logic [31:0]   busy_fp;
  logic [31:0]   set_int;
  logic [31:0]   set_fp;
  logic [31:0]   clr_int;
  logic [31:0]   clr_fp;
  logic [CW-1:0] starve_cnt;

  assign lu_req = '{fp: wb.lu_fp, rd: wb.lu_rd, data: wb.lu_data};
  assign push   = wb.lu_valid && !fifo_full;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (lu_req),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The pipeline has no back-pressure, so it always wins the port.
  always_comb begin
    pop         = !wb.pipe_wb_valid && !fifo_empty;
    owner_valid = wb.pipe_wb_valid || !fifo_empty;
    owner       = '0;
    if (wb.pipe_wb_valid)
      owner = '{fp: wb.pipe_wb_fp, rd: wb.pipe_wb_rd, data: wb.pipe_wb_data};
    else if (!fifo_empty)
      owner = head;
  end

  assign wb.int_wen      = owner_valid && !owner.fp && (owner.rd != '0);
  assign wb.fp_wen       = owner_valid && owner.fp && (owner.rd != '0);
  assign wb.rd_idx       = owner.rd;
  assign wb.wr_data      = owner.data;
  assign wb.lu_ready     = !fifo_full;
  assign wb.sb_busy_int  = busy_int;
  assign wb.sb_busy_fp   = busy_fp;
  assign wb.wb_stall_req = (starve_cnt == CW'(STARVE_LIMIT));

  always_comb begin
    set_int = '0;
    set_fp  = '0;
    clr_int = '0;
    clr_fp  = '0;
    if (wb.iss_valid && (wb.iss_rd != '0)) begin
      if (wb.iss_fp) set_fp[wb.iss_rd]  = 1'b1;
      else           set_int[wb.iss_rd] = 1'b1;
    end
    if (pop) begin
      if (head.fp) clr_fp[head.rd]  = 1'b1;
      else         clr_int[head.rd] = 1'b1;
    end
  end

  // Set is applied after clear so a re-issue in the pop cycle keeps the bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_int <= '0;
      busy_fp  <= '0;
    end else begin
      busy_int <= (busy_int & ~clr_int) | set_int;
      busy_fp  <= (busy_fp & ~clr_fp) | set_fp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_cnt <= '0;
    else if (fifo_empty || pop)
      starve_cnt <= '0;
    else if (starve_cnt != CW'(STARVE_LIMIT))
      starve_cnt <= starve_cnt + 1'b1;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized and directed checks of regfile_wb_arbiter against a queue model
module tb_regfile_wb_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus.slave)
  );

  always #5 clk = ~clk;

  wb_req_t    m_q[$];
  bit [31:0]  m_busy_int;
  bit [31:0]  m_busy_fp;
  int         m_starve;
  bit         prev_stall;

  logic        o_int_wen, o_fp_wen, o_ready, o_stall;
  logic [4:0]  o_rd;
  logic [31:0] o_data, o_busy_int, o_busy_fp;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy_int = '0;
    m_busy_fp  = '0;
    m_starve   = 0;
    prev_stall = 1'b0;
  endtask

  task automatic sample();
    o_int_wen  = bus.int_wen;
    o_fp_wen   = bus.fp_wen;
    o_rd       = bus.rd_idx;
    o_data     = bus.wr_data;
    o_ready    = bus.lu_ready;
    o_stall    = bus.wb_stall_req;
    o_busy_int = bus.sb_busy_int;
    o_busy_fp  = bus.sb_busy_fp;
  endtask

  task automatic drive(input logic pv, input logic pfp, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic lfp, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic iv, input logic ifp, input logic [4:0] ird);
    bus.pipe_wb_valid = pv;  bus.pipe_wb_fp = pfp; bus.pipe_wb_rd = prd; bus.pipe_wb_data = pd;
    bus.lu_valid      = lv;  bus.lu_fp      = lfp; bus.lu_rd      = lrd; bus.lu_data      = ld;
    bus.iss_valid     = iv;  bus.iss_fp     = ifp; bus.iss_rd     = ird;
  endtask

  // One clock cycle: drive, compare against the model's view of this cycle, advance the model.
  task automatic step(input logic pv, input logic pfp, input logic [4:0] prd, input logic [31:0] pd,
                      input logic lv, input logic lfp, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic iv, input logic ifp, input logic [4:0] ird);
    wb_req_t own;
    bit      own_v, popping, accept, e_stall;
    drive(pv, pfp, prd, pd, lv, lfp, lrd, ld, iv, ifp, ird);
    #2;
    sample();
    own = '0; own_v = 0; popping = 0;
    if (pv) begin
      own = '{fp: pfp, rd: prd, data: pd}; own_v = 1;
    end else if (m_q.size() > 0) begin
      own = m_q[0]; own_v = 1; popping = 1;
    end
    accept  = lv && (m_q.size() < DEPTH);
    e_stall = (m_starve == LIMIT);
    check_eq("int_wen",  o_int_wen,  own_v && !own.fp && own.rd != 0);
    check_eq("fp_wen",   o_fp_wen,   own_v && own.fp && own.rd != 0);
    check_eq("rd_idx",   o_rd,       own.rd);
    check_eq("wr_data",  o_data,     own.data);
    check_eq("lu_ready", o_ready,    m_q.size() < DEPTH);
    check_eq("stall",    o_stall,    e_stall);
    check_eq("busy_int", o_busy_int, m_busy_int);
    check_eq("busy_fp",  o_busy_fp,  m_busy_fp);
    if (popping || m_q.size() == 0) m_starve = 0;
    else if (m_starve < LIMIT)       m_starve++;
    if (popping) begin
      if (own.fp) m_busy_fp[own.rd]  = 1'b0;
      else        m_busy_int[own.rd] = 1'b0;
      void'(m_q.pop_front());
    end
    if (iv && ird != 0) begin
      if (ifp) m_busy_fp[ird]  = 1'b1;
      else     m_busy_int[ird] = 1'b1;
    end
    if (accept) m_q.push_back('{fp: lfp, rd: lrd, data: ld});
    prev_stall = e_stall;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    sample();
    check_eq("rst_ready", o_ready, 1);
    check_eq("rst_stall", o_stall, 0);
    check_eq("rst_busy",  {o_busy_int, o_busy_fp}, 64'd0);
    check_eq("rst_wen",   {o_int_wen, o_fp_wen}, 2'b00);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Basic pipeline path
    step(1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    check_eq("x5_wen",  o_int_wen, 1);
    check_eq("x5_rd",   o_rd, 5);
    check_eq("x5_data", o_data, 32'hDEADBEEF);
    step(1, 1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
    check_eq("f0_wen", o_fp_wen, 0);

    // Scoreboard lifecycle on f3
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
    step(0, 0, 0, 0, 1, 1, 3, 32'h3F800000, 0, 0, 0);
    check_eq("f3_busy_set", o_busy_fp[3], 1);
    idle();
    check_eq("f3_wen",  o_fp_wen, 1);
    check_eq("f3_rd",   o_rd, 3);
    check_eq("f3_data", o_data, 32'h3F800000);
    idle();
    check_eq("f3_busy_clr", o_busy_fp[3], 0);

    // Fill with pipe holding the port, then drain in order
    for (int i = 1; i <= 4; i++)
      step(1, 0, 10, 32'hA0 + i, 1, 0, 5'(i), 32'h100 + i, 0, 0, 0);
    step(1, 0, 10, 32'hA5, 0, 0, 0, 0, 0, 0, 0);
    check_eq("full_ready", o_ready, 0);
    idle();
    check_eq("drain1_rd",    o_rd, 1);
    check_eq("drain1_ready", o_ready, 0);
    idle();
    check_eq("drain2_rd",    o_rd, 2);
    check_eq("drain2_ready", o_ready, 1);
    idle();
    check_eq("drain3_rd", o_rd, 3);
    idle();
    check_eq("drain4_rd", o_rd, 4);
    idle();

    // Starvation
    step(1, 0, 11, 32'h1, 1, 0, 12, 32'hC, 0, 0, 0);
    for (int i = 0; i < LIMIT; i++) step(1, 0, 11, 32'h2, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 11, 32'h3, 0, 0, 0, 0, 0, 0, 0);
    check_eq("starve_req", o_stall, 1);
    idle();
    check_eq("starve_pop_rd", o_rd, 12);
    idle();
    check_eq("starve_release", o_stall, 0);

    // Set wins over clear on the same register
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7);
    step(0, 0, 0, 0, 1, 0, 7, 32'h77, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7);
    check_eq("x7_pop_wen", o_int_wen, 1);
    idle();
    check_eq("x7_still_busy", o_busy_int[7], 1);

    // Async reset with buffered entries and busy bits
    step(1, 0, 13, 32'h5, 1, 0, 9, 32'h9, 1, 0, 9);
    step(1, 0, 13, 32'h6, 1, 1, 12, 32'hF, 1, 1, 12);
    step(1, 0, 13, 32'h7, 1, 0, 14, 32'hE, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    sample();
    model_reset();
    check_eq("arst_wen",   {o_int_wen, o_fp_wen}, 2'b00);
    check_eq("arst_rd",    o_rd, 0);
    check_eq("arst_data",  o_data, 0);
    check_eq("arst_ready", o_ready, 1);
    check_eq("arst_stall", o_stall, 0);
    check_eq("arst_busy",  {o_busy_int, o_busy_fp}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) idle();
    check_eq("arst_no_write", {o_int_wen, o_fp_wen}, 2'b00);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic pv;
      pv = ($urandom_range(0, 9) < 6) && !prev_stall;
      step(pv, 1'($urandom), 5'($urandom), $urandom,
           ($urandom_range(0, 1) == 1), 1'($urandom), 5'($urandom), $urandom,
           ($urandom_range(0, 9) < 3), 1'($urandom), 5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
